dmem_stall_ctrl: RTL and testbench

//  Multi-cycle data-memory controller between the processor memory stage and a

---
 rtl/dmem_stall_ctrl_if.sv | 35 +++
 rtl/dmem_stall_ctrl.sv | 125 ++++++++++++
 tb/tb_dmem_stall_ctrl.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_stall_ctrl_if.sv
// Pipeline-side and memory-side signals of the data-memory stall controller.
// Only the memory-side request channel is a handshake, and it is a strobe rather
// than valid/ready. mem_en pulses once per access. mem_addr, mem_wr and
// mem_wdata stay stable until mem_ready. mem_rdata is valid only while
// mem_ready is 1.
interface dmem_stall_ctrl_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16
);
    logic              req_rd;
    logic              req_wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              halt;
    logic              stall;
    logic              done;
    logic [DATA_W-1:0] rdata;
    logic              mem_en;
    logic              mem_wr;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ready;
    logic              err;

    modport slave (
        input  req_rd, req_wr, addr, wdata, halt, mem_rdata, mem_ready,
        output stall, done, rdata, mem_en, mem_wr, mem_addr, mem_wdata, err
    );

    modport master (
        output req_rd, req_wr, addr, wdata, halt, mem_rdata, mem_ready,
        input  stall, done, rdata, mem_en, mem_wr, mem_addr, mem_wdata, err
    );
endinterface

// File: rtl/dmem_stall_ctrl.sv
// Multi-cycle data-memory controller: one access per request, stalls the pipeline
// until the backing memory answers. Optional macro DMEM_ALIGN_CHECK_EN rejects odd addresses.
module dmem_stall_ctrl #(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 16,
    parameter int TIMEOUT = 15
) (
    input  logic               clk,
    input  logic               rst_n,
    dmem_stall_ctrl_if.slave   bus,
    output logic [2:0]         dbg_state
);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ISSUE  = 3'd1,
        S_WAIT   = 3'd2,
        S_DONE   = 3'd3,
        S_HALTED = 3'd4
    } state_t;

    state_t            state, state_nx;
    logic [CNT_W-1:0]  cnt;
    logic              halt_pend;
    logic              err_q;
    logic [DATA_W-1:0] rdata_q;
    logic              mem_wr_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;

    logic one_req, dual_req, misalign, accept, reject, to_hit;
    logic stall_raw, done_c, mem_en_c;

    assign one_req  = bus.req_rd ^ bus.req_wr;
    assign dual_req = bus.req_rd & bus.req_wr;
`ifdef DMEM_ALIGN_CHECK_EN
    assign misalign = bus.addr[0];
`else
    assign misalign = 1'b0;
`endif
    assign accept = (state == S_IDLE) & ~bus.halt & one_req & ~misalign;
    assign reject = (state == S_IDLE) & ~bus.halt & (dual_req | (one_req & misalign));
    // Hit on the WAIT cycle whose increment would bring the counter to TIMEOUT.
    assign to_hit = (cnt == CNT_W'(TIMEOUT - 1));

    always_comb begin
        state_nx  = state;
        stall_raw = 1'b0;
        done_c    = 1'b0;
        mem_en_c  = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.halt) begin
                    state_nx = S_HALTED;
                end else if (accept) begin
                    state_nx  = S_ISSUE;
                    stall_raw = 1'b1;
                end
            end
            S_ISSUE: begin
                mem_en_c  = 1'b1;
                stall_raw = 1'b1;
                state_nx  = S_WAIT;
            end
            S_WAIT: begin
                stall_raw = 1'b1;
                if (bus.mem_ready)   state_nx = S_DONE;
                else if (to_hit)     state_nx = S_IDLE;
            end
            S_DONE: begin
                done_c   = 1'b1;
                state_nx = halt_pend ? S_HALTED : S_IDLE;
            end
            S_HALTED: state_nx = S_HALTED;
            default:  state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nx;
    end

    // Counter saturates at TIMEOUT on the timeout exit, so it never wraps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            halt_pend <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            if (state == S_ISSUE)                        cnt <= '0;
            else if (state == S_WAIT && !bus.mem_ready)  cnt <= cnt + 1'b1;
            if ((state == S_ISSUE || state == S_WAIT) && bus.halt) halt_pend <= 1'b1;
            if (reject || (state == S_WAIT && !bus.mem_ready && to_hit)) err_q <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q     <= '0;
            mem_wr_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            if (accept) begin
                mem_wr_q    <= bus.req_wr;
                mem_addr_q  <= bus.addr;
                mem_wdata_q <= bus.wdata;
            end
            if (state == S_WAIT && bus.mem_ready && !mem_wr_q) rdata_q <= bus.mem_rdata;
        end
    end

    // stall is gated by rst_n so a request held through reset cannot freeze the pipe.
    assign bus.stall     = rst_n & stall_raw;
    assign bus.done      = done_c;
    assign bus.mem_en    = mem_en_c;
    assign bus.rdata     = rdata_q;
    assign bus.mem_wr    = mem_wr_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.err       = err_q;
    assign dbg_state     = state;
endmodule

// File: tb/tb_dmem_stall_ctrl.sv
// Self-checking bench for dmem_stall_ctrl: scoreboarded accesses, latency/stall
// counts, timeout boundary, dual request, halt and alignment behaviour.
module tb_dmem_stall_ctrl;
    localparam int DATA_W  = 16;
    localparam int ADDR_W  = 16;
    localparam int TIMEOUT = 15;
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_WAIT   = 3'd2;
    localparam logic [2:0] ST_HALTED = 3'd4;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b1;
    logic [2:0] dbg_state;

    dmem_stall_ctrl_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    dmem_stall_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // ---------------- scoreboard / monitor ----------------
    logic [32:0]       exp_q[$];     // {mem_wr, mem_addr, mem_wdata} per mem_en
    logic [DATA_W-1:0] exp_rd_q[$];  // load data per done
    int stall_cnt = 0, en_cnt = 0, done_cnt = 0, done_cyc = 0;
    int mem_lat = 1;
    logic [DATA_W-1:0] mem_val = '0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.stall) stall_cnt++;
            if (bus.mem_en) begin
                en_cnt++;
                check("acc_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0)
                    check("acc", {bus.mem_wr, bus.mem_addr, bus.mem_wdata}, exp_q.pop_front());
            end
            if (bus.done) begin
                done_cnt++;
                done_cyc = cyc;
                if (!bus.mem_wr) begin
                    check("rd_expected", exp_rd_q.size() != 0, 1);
                    if (exp_rd_q.size() != 0) check("rdata", bus.rdata, exp_rd_q.pop_front());
                end
            end
        end
    end

    // Backing memory: answers mem_lat cycles after mem_en (mem_lat=0 never answers).
    initial begin
        bus.mem_ready = 1'b0;
        bus.mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (rst_n && bus.mem_en && mem_lat > 0) begin
                repeat (mem_lat) @(posedge clk);
                #1;
                bus.mem_ready = 1'b1;
                bus.mem_rdata = mem_val;
                @(posedge clk);
                #1;
                bus.mem_ready = 1'b0;
                bus.mem_rdata = DATA_W'($urandom);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        exp_q.delete();
        exp_rd_q.delete();
        bus.req_rd = 1'b1;
        bus.req_wr = 1'b0;
        bus.addr   = '0;
        bus.wdata  = '0;
        bus.halt   = 1'b0;
        rst_n      = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_stall_forced_low", bus.stall, 0);
        bus.req_rd = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("rst_state", dbg_state, ST_IDLE);
        check("rst_outputs", {bus.stall, bus.done, bus.mem_en, bus.mem_wr, bus.err,
                              bus.rdata, bus.mem_addr, bus.mem_wdata}, 0);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input string tag, input int budget);
        bit seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (bus.done) begin
                seen = 1'b1;
                break;
            end
        end
        check({tag, "_done_seen"}, seen, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic access(input string tag, input logic wr, input logic [ADDR_W-1:0] a,
                          input logic [DATA_W-1:0] d, input int lat,
                          input logic [DATA_W-1:0] val, input bit hold);
        int s0, e0, n0;
        mem_lat = lat;
        mem_val = val;
        exp_q.push_back({wr, a, d});
        if (!wr) exp_rd_q.push_back(val);
        s0 = stall_cnt;
        e0 = en_cnt;
        n0 = cyc;
        bus.req_rd = ~wr;
        bus.req_wr = wr;
        bus.addr   = a;
        bus.wdata  = d;
        #1 check({tag, "_stall_req_cycle"}, bus.stall, 1);
        @(posedge clk);
        #1;
        if (!hold) begin
            bus.req_rd = 1'b0;
            bus.req_wr = 1'b0;
        end
        wait_done(tag, lat + 10);
        bus.req_rd = 1'b0;
        bus.req_wr = 1'b0;
        check({tag, "_latency"}, done_cyc - n0, lat + 2);
        check({tag, "_stall_cycles"}, stall_cnt - s0, lat + 2);
        repeat (2) @(posedge clk);
        #1 check({tag, "_one_mem_en"}, en_cnt - e0, 1);
    endtask

    task automatic reject_req(input string tag, input logic rd, input logic wr,
                              input logic [ADDR_W-1:0] a);
        int e0 = en_cnt;
        bus.req_rd = rd;
        bus.req_wr = wr;
        bus.addr   = a;
        #1 check({tag, "_stall_low"}, bus.stall, 0);
        @(posedge clk);
        #1;
        bus.req_rd = 1'b0;
        bus.req_wr = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check({tag, "_err"}, bus.err, 1);
        check({tag, "_no_mem_en"}, en_cnt - e0, 0);
        check({tag, "_state"}, dbg_state, ST_IDLE);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int e0, d0, s0;
        #1;
        do_reset();

        access("t1_load", 1'b0, 16'h0010, 16'h0000, 1, 16'hBEEF, 1'b0);
        check("t1_rdata", bus.rdata, 16'hBEEF);
        access("t2_store", 1'b1, 16'h0020, 16'h1234, 5, 16'h5A5A, 1'b0);
        check("t2_err", bus.err, 0);
        check("t2_rdata_hold", bus.rdata, 16'hBEEF);
        check("t2_mem_wdata_hold", {bus.mem_wr, bus.mem_wdata}, {1'b1, 16'h1234});
        access("held_load", 1'b0, 16'h0042, 16'h0000, 2, 16'hC0DE, 1'b1);

        for (int i = 0; i < 4; i++) begin
            logic [ADDR_W-1:0] a;
            a = {15'($urandom_range(0, 32767)), 1'b0};
            access("rand", 1'($urandom_range(0, 1)), a, DATA_W'($urandom),
                   $urandom_range(1, 6), DATA_W'($urandom), 1'b0);
        end

        // Timeout: err must rise exactly after the 15th WAIT cycle.
        mem_lat = 0;
        exp_q.push_back({1'b0, 16'h0030, 16'h0000});
        d0 = done_cnt;
        bus.req_rd = 1'b1;
        bus.addr   = 16'h0030;
        bus.wdata  = 16'h0000;
        @(posedge clk);
        #1 bus.req_rd = 1'b0;
        repeat (TIMEOUT) @(posedge clk);
        @(negedge clk);
        check("t4_err_before_limit", bus.err, 0);
        check("t4_state_before_limit", dbg_state, ST_WAIT);
        @(negedge clk);
        check("t4_err_at_limit", bus.err, 1);
        check("t4_state_idle", dbg_state, ST_IDLE);
        repeat (3) @(posedge clk);
        #1 check("t4_no_done", done_cnt - d0, 0);

        do_reset();
        reject_req("t3_dual", 1'b1, 1'b1, 16'h0044);
        access("t3_after_err", 1'b0, 16'h0046, 16'h0000, 1, 16'h7777, 1'b0);
        check("t3_err_sticky", bus.err, 1);

        do_reset();
`ifdef DMEM_ALIGN_CHECK_EN
        reject_req("t6_misalign", 1'b1, 1'b0, 16'h0003);
`else
        access("t6_odd_load", 1'b0, 16'h0003, 16'h0000, 2, 16'h0BAD, 1'b0);
        check("t6_err", bus.err, 0);
`endif

        // Halt during an in-flight store.
        do_reset();
        mem_lat = 4;
        exp_q.push_back({1'b1, 16'h0050, 16'hABCD});
        d0 = done_cnt;
        bus.req_wr = 1'b1;
        bus.addr   = 16'h0050;
        bus.wdata  = 16'hABCD;
        @(posedge clk);
        #1 bus.req_wr = 1'b0;
        @(posedge clk);
        #1 bus.halt = 1'b1;
        check("t5_halt_in_wait", dbg_state, ST_WAIT);
        @(posedge clk);
        #1 bus.halt = 1'b0;
        wait_done("t5_store", 12);
        check("t5_one_done", done_cnt - d0, 1);
        check("t5_halted", dbg_state, ST_HALTED);
        e0 = en_cnt;
        s0 = stall_cnt;
        bus.req_rd = 1'b1;
        bus.addr   = 16'h0060;
        repeat (5) @(posedge clk);
        #1 bus.req_rd = 1'b0;
        check("t5_no_mem_en", en_cnt - e0, 0);
        check("t5_no_stall", stall_cnt - s0, 0);
        check("t5_still_halted", dbg_state, ST_HALTED);

        check("sb_acc_drained", exp_q.size(), 0);
        check("sb_rd_drained", exp_rd_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d passed", n_pass, n_checks);
        $fatal(1);
    end
endmodule
